// File: rtl/sl_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// sl_tx_scheduler_if
//   Bundles everything between the word sources, the SL transmitter and the
//   scheduler: request/grant handshake, per-frame configuration and the frame
//   outputs driven toward the transmitter.
//
//   slave  modport : the scheduler (takes requests and config, drives grants
//                    and transmitter-side outputs)
//   master modport : the requester/transmitter side
//
//   enable       grants allowed when 1
//   req          per-requester request level, held until ack
//   req_data     requester i word at [i*DATA_W +: DATA_W]
//   cfg_len      word length in bits, sampled at grant
//   cfg_gap      idle cycles after each frame, sampled at frame end
//   ack          one-hot 1-cycle grant pulse
//   tx_data      word for the transmitter, stable for the frame
//   tx_len       clamped length of the current frame
//   tx_send_now  1-cycle start pulse for the transmitter
//   busy         1 while a frame or its gap is in progress
//   done         1-cycle pulse at frame end
//   cur_id       index of the last granted requester
// ---------------------------------------------------------------------------
interface sl_tx_scheduler_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                     enable;
  logic [NREQ-1:0]          req;
  logic [NREQ*DATA_W-1:0]   req_data;
  logic [5:0]               cfg_len;
  logic [15:0]              cfg_gap;
  logic [NREQ-1:0]          ack;
  logic [DATA_W-1:0]        tx_data;
  logic [5:0]               tx_len;
  logic                     tx_send_now;
  logic                     busy;
  logic                     done;
  logic [ID_W-1:0]          cur_id;

  modport master (
    output enable, req, req_data, cfg_len, cfg_gap,
    input  ack, tx_data, tx_len, tx_send_now, busy, done, cur_id
  );

  modport slave (
    input  enable, req, req_data, cfg_len, cfg_gap,
    output ack, tx_data, tx_len, tx_send_now, busy, done, cur_id
  );
endinterface

// File: rtl/sl_tx_scheduler.sv
// ---------------------------------------------------------------------------
// sl_tx_scheduler
//   Shares one SL transmitter between NREQ word sources. A round-robin
//   arbiter picks a requester, its word is latched and a one-cycle
//   tx_send_now is issued; the scheduler then times the serial frame itself
//   ((len + 2) bits of BIT_CLKS cycles: data, parity, stop) and optionally
//   holds off for cfg_gap idle cycles before the next grant.
//
//   clk    system clock (shared with the transmitter)
//   reset  synchronous, active-low
//   bus    sl_tx_scheduler_if.slave: requests, config, grants, tx outputs
//
//   All outputs are registered. Timeline for a grant decided at the edge
//   ending cycle T0-1: ack/tx_send_now in T0, FRAME covers T0..T0+F-1,
//   done in T0+F, which is also the first IDLE cycle when cfg_gap == 0.
// ---------------------------------------------------------------------------
module sl_tx_scheduler #(
  parameter int NREQ     = 4,
  parameter int DATA_W   = 32,
  parameter int BIT_CLKS = 32,
  parameter int LEN_MIN  = 8,
  parameter int LEN_MAX  = 32
) (
  input logic               clk,
  input logic               reset,
  sl_tx_scheduler_if.slave  bus
);

  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2((LEN_MAX + 2) * BIT_CLKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_GAP
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [15:0]         gap_reg, gap_next;
  logic [NREQ-1:0]     ack_reg, ack_next;
  logic [DATA_W-1:0]   tx_data_reg, tx_data_next;
  logic [5:0]          tx_len_reg, tx_len_next;
  logic                send_now_reg, send_now_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic [ID_W-1:0]     cur_id_reg, cur_id_next;

  logic [DATA_W-1:0]   req_word [NREQ];
  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [5:0]          len_clamped;
  logic [CNT_W-1:0]    frame_last;

  // Split the flat request data bus into one word per requester.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_word
      assign req_word[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin: search starts just after the last winner, so the most
  // recently served requester has lowest priority.
  always_comb begin
    int               idx;
    logic [ID_W-1:0]  cand;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(cur_id_reg) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      cand = ID_W'(idx);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    if (bus.cfg_len < 6'(LEN_MIN)) begin
      len_clamped = 6'(LEN_MIN);
    end else if (bus.cfg_len > 6'(LEN_MAX)) begin
      len_clamped = 6'(LEN_MAX);
    end else begin
      len_clamped = bus.cfg_len;
    end
  end

  // Last count value of the frame, derived from the latched length so that
  // cfg_len changes mid-frame have no effect.
  assign frame_last = CNT_W'((int'(tx_len_reg) + 2) * BIT_CLKS - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      gap_reg      <= '0;
      ack_reg      <= '0;
      tx_data_reg  <= '0;
      tx_len_reg   <= '0;
      send_now_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      cur_id_reg   <= ID_W'(NREQ - 1);
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      gap_reg      <= gap_next;
      ack_reg      <= ack_next;
      tx_data_reg  <= tx_data_next;
      tx_len_reg   <= tx_len_next;
      send_now_reg <= send_now_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      cur_id_reg   <= cur_id_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    gap_next      = gap_reg;
    ack_next      = '0;
    tx_data_next  = tx_data_reg;
    tx_len_next   = tx_len_reg;
    send_now_next = 1'b0;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    cur_id_next   = cur_id_reg;

    case (state_reg)
      ST_IDLE: begin
        busy_next = 1'b0;
        if (bus.enable && win_found) begin
          state_next       = ST_FRAME;
          cnt_next         = '0;
          ack_next[win_id] = 1'b1;
          send_now_next    = 1'b1;
          busy_next        = 1'b1;
          tx_data_next     = req_word[win_id];
          tx_len_next      = len_clamped;
          cur_id_next      = win_id;
        end
      end

      ST_FRAME: begin
        if (cnt_reg == frame_last) begin
          done_next = 1'b1;
          if (bus.cfg_gap != 16'd0) begin
            // The done cycle is the first gap cycle, hence the minus one.
            state_next = ST_GAP;
            gap_next   = bus.cfg_gap - 16'd1;
            busy_next  = 1'b1;
          end else begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_reg == 16'd0) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end else begin
          gap_next = gap_reg - 16'd1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.ack         = ack_reg;
  assign bus.tx_data     = tx_data_reg;
  assign bus.tx_len      = tx_len_reg;
  assign bus.tx_send_now = send_now_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.cur_id      = cur_id_reg;

endmodule

// File: tb/tb_sl_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sl_tx_scheduler
//   Scoreboard bench: each expected grant (requester, word, clamped length)
//   is queued when the request is driven and popped when an ack appears.
//   Frame length, spacing, gap and enable behaviour are timed against a
//   free-running cycle counter. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sl_tx_scheduler;
  localparam int NREQ     = 4;
  localparam int DATA_W   = 32;
  localparam int BIT_CLKS = 32;
  localparam int WAIT_MAX = 4000;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic [5:0]  len;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sl_tx_scheduler_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

  sl_tx_scheduler #(
    .NREQ(NREQ), .DATA_W(DATA_W), .BIT_CLKS(BIT_CLKS), .LEN_MIN(8), .LEN_MAX(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [31:0] dword [4] = '{32'h0000E3F1, 32'hA5A50001, 32'h12345602, 32'hDEADBE03};

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   busy_low = 0;
  int   ack_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!bus.busy) busy_low <= busy_low + 1;
    if (bus.ack != '0) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int id, input int len);
    exp_t e;
    e.id   = 2'(id);
    e.data = dword[id];
    e.len  = 6'(len);
    sb_q.push_back(e);
  endtask

  // Waits for the next ack, then checks it against the oldest queued grant.
  task automatic expect_grant(input string tag, output int t0);
    exp_t e;
    for (int k = 0; k < WAIT_MAX; k++) begin
      @(negedge clk);
      if (bus.ack != '0) break;
    end
    check({tag, "_ack_seen"}, 64'(bus.ack != '0), 64'd1);
    t0 = cyc;
    $display("[%0d] %s grant ack=%b id=%0d data=%h len=%0d", cyc, tag, bus.ack,
             bus.cur_id, bus.tx_data, bus.tx_len);
    check({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_ack"},      64'(bus.ack), 64'(4'b0001 << e.id));
      check({tag, "_cur_id"},   64'(bus.cur_id), 64'(e.id));
      check({tag, "_tx_data"},  64'(bus.tx_data), 64'(e.data));
      check({tag, "_tx_len"},   64'(bus.tx_len), 64'(e.len));
      check({tag, "_send_now"}, 64'(bus.tx_send_now), 64'd1);
      check({tag, "_busy"},     64'(bus.busy), 64'd1);
    end
  endtask

  task automatic wait_done(input string tag, output int t);
    for (int k = 0; k < WAIT_MAX; k++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    check({tag, "_done_seen"}, 64'(bus.done), 64'd1);
    t = cyc;
    $display("[%0d] %s done busy=%0d", cyc, tag, bus.busy);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < WAIT_MAX; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},      64'(bus.ack), 64'd0);
    check({tag, "_tx_data"},  64'(bus.tx_data), 64'd0);
    check({tag, "_tx_len"},   64'(bus.tx_len), 64'd0);
    check({tag, "_send_now"}, 64'(bus.tx_send_now), 64'd0);
    check({tag, "_busy"},     64'(bus.busy), 64'd0);
    check({tag, "_done"},     64'(bus.done), 64'd0);
    check({tag, "_cur_id"},   64'(bus.cur_id), 64'(NREQ - 1));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs(tag);
    $display("[%0d] %s reset applied", cyc, tag);
    reset = 1'b1;
  endtask

  initial begin
    int t0, t1, td, prev, b0, a0;
    bus.enable   = 1'b1;
    bus.req      = '0;
    bus.req_data = {dword[3], dword[2], dword[1], dword[0]};
    bus.cfg_len  = 6'd16;
    bus.cfg_gap  = 16'd0;

    // 1: single word, len 16, no gap
    do_reset("rst1");
    push_exp(0, 16);
    bus.req = 4'b0001;
    expect_grant("t1", t0);
    bus.req = 4'b0000;
    @(negedge clk);
    check("t1_send_now_pulse", 64'(bus.tx_send_now), 64'd0);
    check("t1_ack_pulse", 64'(bus.ack), 64'd0);
    wait_done("t1", td);
    check("t1_frame_len", 64'(td - t0), 64'd576);
    check("t1_busy_at_done", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("t1_done_pulse", 64'(bus.done), 64'd0);
    check("t1_tx_data_hold", 64'(bus.tx_data), 64'h0000E3F1);

    // 2: all requesting, round-robin order and spacing
    do_reset("rst2");
    for (int i = 0; i < 5; i++) push_exp(i % 4, 16);
    bus.req = 4'b1111;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      expect_grant($sformatf("t2_g%0d", i), t1);
      if (i > 0) check($sformatf("t2_spacing%0d", i), 64'(t1 - prev), 64'd577);
      prev = t1;
    end
    bus.req = 4'b0000;
    wait_done("t2", td);

    // 3: length clamping at both ends; cfg change mid-frame ignored
    @(negedge clk);
    bus.cfg_len = 6'd5;
    push_exp(0, 8);
    bus.req = 4'b0001;
    expect_grant("t3a", t0);
    bus.req = 4'b0000;
    wait_done("t3a", td);
    check("t3a_frame_len", 64'(td - t0), 64'd320);
    bus.cfg_len = 6'd40;
    push_exp(0, 32);
    bus.req = 4'b0001;
    expect_grant("t3b", t0);
    bus.req = 4'b0000;
    bus.cfg_len = 6'd8;
    wait_done("t3b", td);
    check("t3b_frame_len", 64'(td - t0), 64'd1088);
    check("t3b_len_hold", 64'(bus.tx_len), 64'd32);

    // 4: gap of 100 with req0 held
    bus.cfg_len = 6'd16;
    bus.cfg_gap = 16'd100;
    push_exp(0, 16);
    push_exp(0, 16);
    bus.req = 4'b0001;
    expect_grant("t4a", t0);
    b0 = busy_low;
    expect_grant("t4b", t1);
    bus.req = 4'b0000;
    check("t4_ack_spacing", 64'(t1 - t0), 64'd677);
    check("t4_busy_low_cycles", 64'(busy_low - b0), 64'd1);
    wait_done("t4b", td);
    check("t4_busy_in_gap", 64'(bus.busy), 64'd1);
    wait_idle("t4");
    bus.cfg_gap = 16'd0;

    // 5: reset mid-frame, then priority restarts from requester 0
    push_exp(0, 16);
    bus.req = 4'b0001;
    expect_grant("t5a", t0);
    bus.req = 4'b0000;
    while (cyc < t0 + 199) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("t5_abort");
    bus.req = 4'b0110;
    @(negedge clk);
    reset = 1'b1;
    push_exp(1, 16);
    expect_grant("t5b", t0);
    bus.req = 4'b0000;
    wait_done("t5b", td);
    check("t5b_frame_len", 64'(td - t0), 64'd576);

    // 6: enable dropped mid-frame
    @(negedge clk);
    push_exp(0, 16);
    bus.req = 4'b0001;
    expect_grant("t6a", t0);
    while (cyc < t0 + 10) @(negedge clk);
    bus.enable = 1'b0;
    wait_done("t6a", td);
    check("t6_frame_len", 64'(td - t0), 64'd576);
    a0 = ack_cnt;
    repeat (50) @(negedge clk);
    check("t6_no_ack_disabled", 64'(ack_cnt - a0), 64'd0);
    check("t6_idle_disabled", 64'(bus.busy), 64'd0);
    push_exp(0, 16);
    bus.enable = 1'b1;
    expect_grant("t6b", t0);
    bus.req = 4'b0000;
    wait_done("t6b", td);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
